io_port: RTL and testbench
==========================

IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter WORD_WIDTH, default 16, width of the internal data bus and both FIFO words.
REQ-002 Parameter DEPTH, default 4, entries per FIFO; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port io_oe  input  1  read strobe from the control unit.
REQ-006 Port io_we  input  1  write strobe from the control unit.
REQ-007 Port io_sel  input  1  port select: 0 = data port, 1 = status/control port.
REQ-008 Port bus_in  input  WORD_WIDTH  internal data bus value, sampled on a write.
REQ-009 Port bus_out  output  WORD_WIDTH  value this block drives onto the bus while reading; 0 otherwise.
REQ-010 Port in_data  input  WORD_WIDTH  keypad word.
REQ-011 Port in_valid  input  1  keypad word valid.
REQ-012 Port in_ready  output  1  RX FIFO can accept a word.
REQ-013 Port out_data  output  WORD_WIDTH  display word, the TX FIFO head.
REQ-014 Port out_valid  output  1  TX FIFO is non-empty.
REQ-015 Port out_ready  input  1  display accepts a word.

Function
REQ-016 RX push: the word is pushed when in_valid && in_ready at a rising edge; in_ready = (rx_count < DEPTH), combinational from the registered count.
REQ-017 RX pop on a data-port read (io_oe=1, io_we=0, io_sel=0):
- bus_out = RX head, combinationally, in the same cycle.
- The head is popped at the edge.
- If RX is empty: bus_out = 0, no pop, and rx_underflow is set.
REQ-018 A word pushed at edge N is readable on the bus from cycle N+1; latency is one cycle.
REQ-019 RX push and pop in the same cycle: both take effect and rx_count is unchanged. When empty, only the push takes effect and rx_underflow is set.
REQ-020 TX push on a data-port write (io_we=1, io_sel=0): bus_in is pushed at the edge.
REQ-021 TX push when full: accepted if out_valid && out_ready pops in the same cycle; otherwise the word is dropped and tx_overflow is set.
REQ-022 TX pop occurs when out_valid && out_ready at the edge. A word written at edge N appears on out_data with out_valid=1 from cycle N+1.
REQ-023 Status read (io_oe=1, io_we=0, io_sel=1) drives bus_out with:
- [2:0] rx_count
- [5:3] tx_count
- [6] rx_underflow
- [7] tx_overflow
- remaining bits 0
REQ-024 A status read clears both sticky flags at the edge. A flag set by an event in the same cycle wins over the clear.
REQ-025 Control write (io_we=1, io_sel=1) with bus_in[0]=1 flushes both FIFOs and both stickies at the edge. Flush wins over any same-cycle push or pop, and a same-cycle keypad word is discarded. A control write with bus_in[0]=0 has no effect.
REQ-026 io_oe and io_we both high: the write is performed, the read is ignored, bus_out=0, and no pop occurs.
REQ-027 Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits and never exceed DEPTH.
REQ-028 The block has no internal state machine beyond FIFO pointers, counts and stickies. Every output is a function of registered state plus the current strobes.

Reset
REQ-029 While rst=1, and asynchronously on its assertion, the following are cleared:
- all pointers and counts are 0
- both stickies are 0
- FIFO contents need not be cleared
REQ-030 Output values during reset: in_ready=1, out_valid=0, out_data=0 (masked while empty), bus_out=0.
REQ-031 Reset asserted mid-transfer discards all buffered words. The first edge after deassertion behaves as from the empty state.

Structure
REQ-032 Shared package calc_pkg SHALL hold WORD_WIDTH, IO_DEPTH, the io_sel codes (IO_DATA=0, IO_STATUS=1), status bit positions and the flush bit index.
REQ-033 One sub-module io_fifo SHALL be instantiated twice, as RX and TX. It provides:
- push and pop inputs
- full, empty, count and head outputs
- flush input
- asynchronous reset

Verification
REQ-034 Keypad pushes 0x0011, 0x0022, 0x0033, 0x0044, then in_valid is held -> in_ready=0 after the 4th word; status reads rx_count=4; four data reads return 0x0011..0x0044 in order.
REQ-035 Data read with RX empty -> bus_out=0; the following status read shows bit6=1; a second status read shows bit6=0.
REQ-036 out_ready=0, CPU writes 5 words starting at 0x1234 -> 5th word dropped, status bit7=1, tx_count=4. Then out_ready=1 -> 0x1234 and the next three words delivered, one per cycle.
REQ-037 TX full and out_ready=1, with a write of 0xBEEF in the same cycle -> write accepted, tx_count stays 4, 0xBEEF delivered last.
REQ-038 RX holding 2 words, control write 0x0001 while in_valid=1 -> rx_count=0, keypad word discarded, stickies 0.
REQ-039 rst pulsed asynchronously between clock edges with both FIFOs holding data -> in_ready=1 and out_valid=0 immediately; a status read after deassertion returns 0x0000.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared constants for the calculator I/O block: default bus width and FIFO
// depth, io_sel port codes, the bit layout of the status word and the flush
// bit of the control word. Also a helper that packs the 8-bit status field.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IO_DEPTH   = 4;

    // io_sel codes
    localparam logic IO_DATA   = 1'b0;
    localparam logic IO_STATUS = 1'b1;

    // Status word layout (bits above ST_TX_OVERFLOW read as zero)
    localparam int ST_RX_COUNT_LSB = 0;
    localparam int ST_TX_COUNT_LSB = 3;
    localparam int ST_COUNT_BITS   = 3;
    localparam int ST_RX_UNDERFLOW = 6;
    localparam int ST_TX_OVERFLOW  = 7;

    // Control word: writing 1 here flushes both FIFOs and both stickies
    localparam int CTRL_FLUSH_BIT = 0;

    // Counts arrive zero-extended to 8 bits; only the low ST_COUNT_BITS fit.
    function automatic logic [7:0] pack_status(
        input logic [7:0] rx_count,
        input logic [7:0] tx_count,
        input logic       rx_underflow,
        input logic       tx_overflow
    );
        logic [7:0] s;
        s = '0;
        s[ST_RX_COUNT_LSB +: ST_COUNT_BITS] = rx_count[ST_COUNT_BITS-1:0];
        s[ST_TX_COUNT_LSB +: ST_COUNT_BITS] = tx_count[ST_COUNT_BITS-1:0];
        s[ST_RX_UNDERFLOW]                  = rx_underflow;
        s[ST_TX_OVERFLOW]                   = tx_overflow;
        return s;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// ---------------------------------------------------------------------------
// io_fifo
// Small synchronous FIFO used for both the keypad (RX) and display (TX)
// paths. A pop is honoured only when non-empty; a push is honoured when not
// full, or when full and a pop happens in the same cycle. Flush empties the
// FIFO and wins over any same-cycle push or pop.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : push request and word
//   pop             : pop request
//   flush           : synchronous clear of pointers and count
//   head            : oldest word, forced to 0 while empty
//   count           : number of stored words (0..DEPTH)
//   full, empty     : count == DEPTH / count == 0
// ---------------------------------------------------------------------------
import calc_pkg::*;

module io_fifo #(
    parameter int WIDTH = calc_pkg::WORD_WIDTH,
    parameter int DEPTH = calc_pkg::IO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

    // A full FIFO can still take a word if the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are DEPTH-sized powers of two, so they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale words are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/io_port.sv
// ---------------------------------------------------------------------------
// io_port
// CPU-facing I/O port: keypad words are queued in an RX FIFO and read by
// the CPU through the data port; CPU writes to the data port are queued in a
// TX FIFO that feeds the display. A status port reports both counts plus two
// sticky error flags (RX underflow, TX overflow); a control write can flush
// everything.
//
// Handshakes: in_valid/in_ready and out_valid/out_ready follow valid/ready
// semantics -- a word moves at a rising edge where both are high; valid does
// not depend on ready.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   io_oe, io_we, io_sel  : CPU read/write strobes and port select
//   bus_in                : CPU write data
//   bus_out               : CPU read data (0 when not reading)
//   in_data/valid/ready   : keypad stream into RX FIFO
//   out_data/valid/ready  : display stream out of TX FIFO
// ---------------------------------------------------------------------------
import calc_pkg::*;

module io_port #(
    parameter int WORD_WIDTH = calc_pkg::WORD_WIDTH,
    parameter int DEPTH      = calc_pkg::IO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_oe,
    input  logic                  io_we,
    input  logic                  io_sel,
    input  logic [WORD_WIDTH-1:0] bus_in,
    output logic [WORD_WIDTH-1:0] bus_out,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  rd;
    logic                  data_rd;
    logic                  status_rd;
    logic                  data_wr;
    logic                  flush;

    logic [WORD_WIDTH-1:0] rx_head;
    logic [CW-1:0]         rx_count;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  rx_pop;

    logic [CW-1:0]         tx_count;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_pop;

    logic                  rx_underflow;
    logic                  tx_overflow;
    logic                  underflow_evt;
    logic                  overflow_evt;
    logic [7:0]            status;

    // A simultaneous read and write is treated as a write only.
    assign rd        = io_oe && !io_we;
    assign data_rd   = rd && (io_sel == IO_DATA);
    assign status_rd = rd && (io_sel == IO_STATUS);
    assign data_wr   = io_we && (io_sel == IO_DATA);
    assign flush     = io_we && (io_sel == IO_STATUS) && bus_in[CTRL_FLUSH_BIT];

    assign in_ready  = !rx_full;
    assign rx_push   = in_valid && in_ready;
    assign rx_pop    = data_rd && !rx_empty;

    assign out_valid = !tx_empty;
    assign tx_pop    = out_valid && out_ready;

    assign underflow_evt = data_rd && rx_empty;
    // Dropped only if full and the display does not free a slot this cycle.
    assign overflow_evt  = data_wr && tx_full && !tx_pop;

    io_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (in_data),
        .pop   (rx_pop),
        .flush (flush),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    io_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .wdata (bus_in),
        .pop   (tx_pop),
        .flush (flush),
        .head  (out_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign status = pack_status(8'(rx_count), 8'(tx_count), rx_underflow, tx_overflow);

    always_comb begin
        bus_out = '0;
        if (data_rd)        bus_out = rx_head;
        else if (status_rd) bus_out = WORD_WIDTH'(status);
    end

    // A new event in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else if (flush) begin
            rx_underflow <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            rx_underflow <= underflow_evt || (rx_underflow && !status_rd);
            tx_overflow  <= overflow_evt  || (tx_overflow  && !status_rd);
        end
    end

endmodule

// File: tb/tb_io_port.sv
// ---------------------------------------------------------------------------
// tb_io_port
// Directed scenarios for io_port followed by a randomized run checked
// against a queue-based reference model of the port.
// ---------------------------------------------------------------------------
module tb_io_port;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         io_oe;
    logic         io_we;
    logic         io_sel;
    logic [W-1:0] bus_in;
    logic [W-1:0] bus_out;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] rx_q [$];
    logic [W-1:0] tx_q [$];
    logic         m_uf;
    logic         m_of;

    io_port #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_oe     (io_oe),
        .io_we     (io_we),
        .io_sel    (io_sel),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io_oe = 0; io_we = 0; io_sel = 0; bus_in = '0;
        in_valid = 0; in_data = '0; out_ready = 0;
    endtask

    // Asynchronous pulse between edges
    task automatic pulse_reset();
        idle();
        rst = 1;
        #2;
        rst = 0;
        tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic cpu(input logic oe, input logic we, input logic sel, input logic [W-1:0] d);
        io_oe = oe; io_we = we; io_sel = sel; bus_in = d;
    endtask

    // ---------------- model ----------------
    function automatic logic [W-1:0] model_status();
        logic [W-1:0] s;
        s = W'(rx_q.size()) | (W'(tx_q.size()) << 3);
        if (m_uf) s = s | 16'h0040;
        if (m_of) s = s | 16'h0080;
        return s;
    endfunction

    task automatic model_update();
        logic rd_data, rd_stat, wr_data, do_flush, uf_evt, of_evt, rx_push, tx_pop;
        rd_data  = io_oe && !io_we && !io_sel;
        rd_stat  = io_oe && !io_we && io_sel;
        wr_data  = io_we && !io_sel;
        do_flush = io_we && io_sel && bus_in[0];
        if (do_flush) begin
            rx_q.delete(); tx_q.delete(); m_uf = 0; m_of = 0;
        end else begin
            uf_evt  = rd_data && (rx_q.size() == 0);
            rx_push = in_valid && (rx_q.size() < D);
            if (rd_data && rx_q.size() > 0) void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(in_data);
            tx_pop = out_ready && (tx_q.size() > 0);
            of_evt = wr_data && (tx_q.size() == D) && !tx_pop;
            if (tx_pop) void'(tx_q.pop_front());
            if (wr_data && !of_evt) tx_q.push_back(bus_in);
            m_uf = uf_evt || (m_uf && !rd_stat);
            m_of = of_evt || (m_of && !rd_stat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_status got=%h exp=0000", bus_out); end
        idle();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_rx_fill();
        logic [W-1:0] exp;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = W'(16'h0011 * (i + 1));
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rx_fill_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
        end
        in_data = 16'h0055;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 0;
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0004) begin n_fail++; $display("FAIL rx_fill_status got=%h exp=0004", bus_out); end
        tick();
        for (int i = 0; i < 4; i++) begin
            cpu(1, 0, 0, '0);
            exp = W'(16'h0011 * (i + 1));
            #1;
            n_checks++; if (bus_out !== exp) begin n_fail++; $display("FAIL rx_read[%0d] got=%h exp=%h", i, bus_out, exp); end
            tick();
        end
        idle();
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rx_drained_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_underflow();
        pulse_reset();
        cpu(1, 0, 0, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL underflow_read got=%h exp=0000", bus_out); end
        tick();
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0040) begin n_fail++; $display("FAIL underflow_status1 got=%h exp=0040", bus_out); end
        tick();
        #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL underflow_status2 got=%h exp=0000", bus_out); end
        tick();
        idle();
    endtask

    task automatic test_tx_overflow();
        logic [W-1:0] exp;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            cpu(0, 1, 0, W'(16'h1234 + i));
            tick();
        end
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h00A0) begin n_fail++; $display("FAIL tx_overflow_status got=%h exp=00a0", bus_out); end
        tick();
        idle();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp = W'(16'h1234 + i);
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL tx_drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp); end
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained_valid got=%b exp=0", out_valid); end
        idle();
    endtask

    task automatic test_tx_full_accept();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] exp;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            cpu(0, 1, 0, W'(16'hA000 + i));
            tick();
        end
        cpu(0, 1, 0, 16'hBEEF);
        out_ready = 1;
        #1;
        n_checks++; if (out_data !== 16'hA000) begin n_fail++; $display("FAIL tx_full_head got=%h exp=a000", out_data); end
        tick();
        out_ready = 0;
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0020) begin n_fail++; $display("FAIL tx_full_status got=%h exp=0020", bus_out); end
        tick();
        idle();
        exp_q = '{16'hA001, 16'hA002, 16'hA003, 16'hBEEF};
        out_ready = 1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL tx_full_drain got=%b/%h exp=1/%h", out_valid, out_data, exp); end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        pulse_reset();
        cpu(1, 0, 0, '0);                 // underflow sets sticky
        tick();
        cpu(0, 1, 0, 16'h5A5A);           // one TX word, display stalled
        in_valid = 1; in_data = 16'h0101;
        tick();
        cpu(0, 0, 0, '0);
        in_data = 16'h0202;
        tick();
        cpu(0, 1, 1, 16'h0000);           // control write without flush bit
        in_valid = 0;
        tick();
        cpu(0, 1, 1, 16'h0001);           // flush with keypad word present
        in_valid = 1; in_data = 16'h0303;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin n_fail++; $display("FAIL noop_ctrl_tx got=%b/%h exp=1/5a5a", out_valid, out_data); end
        tick();
        idle();
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL flush_status got=%h exp=0000", bus_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = W'(16'h0700 + i);
            if (i < 2) cpu(0, 1, 0, W'(16'h0900 + i)); else cpu(0, 0, 0, '0);
            tick();
        end
        idle();
        #1;
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got=%b/%b exp=0/1", in_ready, out_valid); end
        rst = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin n_fail++; $display("FAIL async_rst_out got=%b/%h exp=0/0000", out_valid, out_data); end
        #1;
        rst = 0;
        tick();
        cpu(1, 0, 1, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL post_reset_status got=%h exp=0000", bus_out); end
        tick();
        idle();
        in_valid = 1; in_data = 16'h0077;
        tick();
        idle();
        cpu(1, 0, 0, '0);
        #1;
        n_checks++; if (bus_out !== 16'h0077) begin n_fail++; $display("FAIL post_reset_read got=%h exp=0077", bus_out); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int r;
        logic [W-1:0] exp_bus, exp_out;
        pulse_reset();
        rx_q.delete(); tx_q.delete(); m_uf = 0; m_of = 0;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            io_oe  = (r < 3) || (r == 6);
            io_we  = (r >= 3 && r < 7);
            io_sel = ($urandom_range(0, 3) == 0);
            bus_in = W'($urandom);
            bus_in[0] = ($urandom_range(0, 15) == 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (io_oe && !io_we && !io_sel)     exp_bus = (rx_q.size() > 0) ? rx_q[0] : '0;
            else if (io_oe && !io_we && io_sel) exp_bus = model_status();
            else                                exp_bus = '0;
            exp_out = (tx_q.size() > 0) ? tx_q[0] : '0;
            n_checks++; if (bus_out !== exp_bus) begin n_fail++; $display("FAIL rnd_bus_out c=%0d got=%h exp=%h", c, bus_out, exp_bus); end
            n_checks++; if (in_ready !== (rx_q.size() < D)) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, rx_q.size() < D); end
            n_checks++; if (out_valid !== (tx_q.size() > 0) || out_data !== exp_out) begin n_fail++; $display("FAIL rnd_out c=%0d got=%b/%h exp=%b/%h", c, out_valid, out_data, tx_q.size() > 0, exp_out); end
            model_update();
            tick();
        end
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1;
        idle();
        test_reset();
        test_rx_fill();
        test_underflow();
        test_tx_overflow();
        test_tx_full_accept();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
